jk_mod_counter: RTL and testbench

Parametrised synchronous modulo counter built from a bank of JK flip-flop bit cells. It generalises the single toggle flip-flop to WIDTH bits and adds up/down/load/hold modes, a programmable maximum, and wrap or saturate behaviour. It is the standard counter primitive for timers, dividers and sequencers in the misc library.

---
 rtl/jk_pkg.sv | 18 +
 rtl/jk_bit_cell.sv | 37 +++
 rtl/jk_mod_counter.sv | 99 +++++++++
 tb/tb_jk_mod_counter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared constants for the JK-cell based modulo counter.
//   mode_e  : counter operation select (hold / up / down / load)
//   JK_*    : {j,k} drive codes applied to a single JK flip-flop cell
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_bit_cell.sv
// Single JK flip-flop with asynchronous active-high reset to 0.
//   clk : rising-edge clock
//   rst : async reset, active-high
//   j,k : JK drive inputs ({j,k} coded per jk_pkg::JK_*)
//   q   : registered cell state
module jk_bit_cell
  import jk_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic state_q;
  logic state_d;

  // Next-state decode of the JK code; toggle is kept for a complete cell.
  always_comb begin
    state_d = state_q;
    case ({j, k})
      JK_SET:    state_d = 1'b1;
      JK_RESET:  state_d = 1'b0;
      JK_TOGGLE: state_d = ~state_q;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= 1'b0;
    else     state_q <= state_d;
  end

  assign q = state_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Parametrised modulo counter built from WIDTH JK flip-flop cells.
// Supports hold / up / down / load, a programmable maximum, and wrap or
// saturate behaviour at the limits.
//   clk, rst : rising-edge clock, async active-high reset
//   en       : count enable (0 forces hold)
//   mode     : 00 hold, 01 up, 10 down, 11 load
//   load_val : value taken in load mode (clamped to MAX)
//   q        : registered count
//   qb       : ~q (combinational)
//   at_max   : q == MAX (combinational)
//   at_zero  : q == 0 (combinational)
//   wrap     : registered one-cycle pulse on a wrapping edge
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int unsigned          WIDTH    = 8,
  parameter logic [WIDTH-1:0]     MAX      = {WIDTH{1'b1}},
  parameter bit                   SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             at_max,
  output logic             at_zero,
  output logic             wrap
);

  logic [WIDTH-1:0] nxt_c;
  logic [WIDTH-1:0] j_c;
  logic [WIDTH-1:0] k_c;
  logic             wrap_d;
  logic             wrap_q;

  // Next count and wrap flag from current count, mode and parameters.
  always_comb begin
    nxt_c  = q;
    wrap_d = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          // Values above MAX are unreachable but recover like MAX.
          if (q < MAX) begin
            nxt_c = q + WIDTH'(1);
          end else if (SATURATE) begin
            nxt_c = MAX;
          end else begin
            nxt_c  = '0;
            wrap_d = 1'b1;
          end
        end
        MODE_DOWN: begin
          if (q != '0) begin
            nxt_c = q - WIDTH'(1);
          end else if (SATURATE) begin
            nxt_c = '0;
          end else begin
            nxt_c  = MAX;
            wrap_d = 1'b1;
          end
        end
        MODE_LOAD: begin
          nxt_c = (load_val > MAX) ? MAX : load_val;
        end
        default: begin
          nxt_c = q;
        end
      endcase
    end
  end

  // Set bits that rise, reset bits that fall; toggle code never arises.
  assign j_c = ~q & nxt_c;
  assign k_c = q & ~nxt_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_bit_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j_c[i]),
      .k   (k_c[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap    = wrap_q;
  assign qb      = ~q;
  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

endmodule

// File: tb/tb_jk_mod_counter.sv
// Bench for jk_mod_counter: a wrapping and a saturating instance (WIDTH=4,
// MAX=9) share one stimulus stream and are compared against an
// arithmetic reference model every cycle, plus directed literal checks.
module tb_jk_mod_counter;

  localparam int unsigned W = 4;
  localparam logic [W-1:0] MAXV = 4'd9;
  localparam int unsigned MAXI = 9;

  logic         clk;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] load_val;

  logic [W-1:0] q_w, qb_w, q_s, qb_s;
  logic         atmax_w, atzero_w, wrap_w;
  logic         atmax_s, atzero_s, wrap_s;

  int checks = 0;
  int errors = 0;

  // Model state: index 0 = wrapping instance, 1 = saturating instance.
  int unsigned mq [2];
  bit          mw [2];

  jk_mod_counter #(.WIDTH(W), .MAX(MAXV), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .q(q_w), .qb(qb_w), .at_max(atmax_w), .at_zero(atzero_w), .wrap(wrap_w)
  );

  jk_mod_counter #(.WIDTH(W), .MAX(MAXV), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load_val(load_val),
    .q(q_s), .qb(qb_s), .at_max(atmax_s), .at_zero(atzero_s), .wrap(wrap_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Reference next value from the counter rules in plain integer arithmetic.
  function automatic int unsigned ref_next(input int unsigned cur, input logic [1:0] md,
                                           input logic e, input int unsigned ld,
                                           input bit sat, output bit w);
    int unsigned r;
    w = 1'b0;
    r = cur;
    if (e) begin
      if (md == 2'd1) begin
        if (cur < MAXI) r = cur + 1;
        else if (sat) r = MAXI;
        else begin r = 0; w = 1'b1; end
      end else if (md == 2'd2) begin
        if (cur > 0) r = cur - 1;
        else if (sat) r = 0;
        else begin r = MAXI; w = 1'b1; end
      end else if (md == 2'd3) begin
        r = (ld > MAXI) ? MAXI : ld;
      end
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        mq[i] = 0;
        mw[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        bit w;
        mq[i] = ref_next(mq[i], mode, en, int'(load_val), (i == 1), w);
        mw[i] = w;
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    chk("q_wrap",       int'(q_w), mq[0]);
    chk("qb_wrap",      int'(qb_w), (~mq[0]) & 32'hF);
    chk("at_max_wrap",  int'(atmax_w), int'(mq[0] == MAXI));
    chk("at_zero_wrap", int'(atzero_w), int'(mq[0] == 0));
    chk("wrap_wrap",    int'(wrap_w), int'(mw[0]));
    chk("q_sat",        int'(q_s), mq[1]);
    chk("qb_sat",       int'(qb_s), (~mq[1]) & 32'hF);
    chk("at_max_sat",   int'(atmax_s), int'(mq[1] == MAXI));
    chk("at_zero_sat",  int'(atzero_s), int'(mq[1] == 0));
    chk("wrap_sat",     int'(wrap_s), int'(mw[1]));
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; load_val = '0;
    step(2);
    chk("reset_q", int'(q_w), 0);
    chk("reset_qb", int'(qb_w), 15);
    chk("reset_at_zero", int'(atzero_w), 1);
    chk("reset_at_max", int'(atmax_w), 0);
    rst = 1'b0;

    // Count to 5, then async reset between edges.
    en = 1'b1; mode = 2'd1;
    step(5);
    chk("count5", int'(q_w), 5);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_q", int'(q_w), 0);
    chk("async_rst_q_sat", int'(q_s), 0);
    chk("async_rst_wrap", int'(wrap_w), 0);
    step(1);
    chk("rst_held_q", int'(q_w), 0);
    rst = 1'b0;
    step(1);
    chk("first_after_rst", int'(q_w), 1);

    // Wrap up / saturate up.
    step(8);
    chk("up_at9", int'(q_w), 9);
    chk("up_at_max", int'(atmax_w), 1);
    chk("up_wrap_low_at9", int'(wrap_w), 0);
    step(1);
    chk("up_wrapped_q", int'(q_w), 0);
    chk("up_wrap_pulse", int'(wrap_w), 1);
    chk("sat_hold_q", int'(q_s), 9);
    chk("sat_no_wrap", int'(wrap_s), 0);
    step(1);
    chk("up_after_wrap", int'(q_w), 1);
    chk("wrap_one_cycle", int'(wrap_w), 0);
    step(2);
    chk("sat_still9", int'(q_s), 9);

    // Wrap down / saturate down.
    mode = 2'd3; load_val = 4'd0;
    step(1);
    chk("load0", int'(q_w), 0);
    mode = 2'd2;
    step(1);
    chk("down_wrap_q", int'(q_w), 9);
    chk("down_wrap_pulse", int'(wrap_w), 1);
    chk("sat_down_q", int'(q_s), 0);
    step(1);
    chk("down_8", int'(q_w), 8);
    chk("down_wrap_clear", int'(wrap_w), 0);
    step(1);
    chk("sat_down_still0", int'(q_s), 0);

    // Load clamp.
    mode = 2'd3; load_val = 4'd13;
    step(1);
    chk("load_clamp", int'(q_w), 9);
    chk("load_clamp_qb", int'(qb_w), 6);
    load_val = 4'd4;
    step(1);
    chk("load4", int'(q_w), 4);

    // Enable gating.
    en = 1'b0; mode = 2'd1;
    step(5);
    chk("en0_hold", int'(q_w), 4);
    chk("en0_wrap", int'(wrap_w), 0);
    en = 1'b1;
    step(1);
    chk("en1_resume", int'(q_w), 5);

    // Randomised phase checked by the per-cycle compare process.
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 7) != 0);
      mode     = 2'($urandom_range(0, 3));
      load_val = W'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #2 rst = 1'b0;
      end
      step(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
